hamming_stream_encoder: RTL and testbench

Streaming Hamming(16,11) SECDED encoder that sits directly upstream of `hamming_decoder`. It accepts 11-bit data words over a valid/ready handshake and computes the 16-bit codeword in the exact bit layout the decoder consumes. It buffers codewords in a 2-entry output FIFO. An optional per-word error-injection mask lets the link to the decoder be exercised with single-bit and double-bit faults.

---
 rtl/hamming_pkg.sv | 25 ++
 rtl/hamming_enc_core.sv | 30 +++
 rtl/hamming_stream_encoder.sv | 95 +++++++++
 tb/tb_hamming_stream_encoder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared Hamming(16,11) SECDED constants and types
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 16;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CODE_W-1:0] code_t;

    // Codeword positions are 1-based; bit k-1 of a code_t holds position k.
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    localparam int P1_POS  = 1;
    localparam int P2_POS  = 2;
    localparam int P4_POS  = 4;
    localparam int P8_POS  = 8;
    localparam int P16_POS = 16;

    // Positions covered by each Hamming parity bit, as code_t bit masks.
    localparam code_t P1_COVER = 16'h5554;
    localparam code_t P2_COVER = 16'h6664;
    localparam code_t P4_COVER = 16'h7870;
    localparam code_t P8_COVER = 16'h7F00;

endpackage

// File: rtl/hamming_enc_core.sv
// rtl/hamming_enc_core.sv - combinational Hamming(16,11) SECDED encoder
module hamming_enc_core
    import hamming_pkg::*;
(
    input  data_t data,
    output code_t code
);

    code_t placed;
    logic  p1, p2, p4, p8;

    always_comb begin
        placed = {1'b0, data[10:4], 1'b0, data[3:1], 1'b0, data[0], 2'b00};
        p1 = ^(placed & P1_COVER);
        p2 = ^(placed & P2_COVER);
        p4 = ^(placed & P4_COVER);
        p8 = ^(placed & P8_COVER);
    end

    // Overall parity covers the data and the four Hamming parity bits.
    always_comb begin
        code = placed;
        code[P1_POS-1] = p1;
        code[P2_POS-1] = p2;
        code[P4_POS-1] = p4;
        code[P8_POS-1] = p8;
        code[P16_POS-1] = ^placed[14:0] ^ p1 ^ p2 ^ p4 ^ p8;
    end

endmodule

// File: rtl/hamming_stream_encoder.sv
// rtl/hamming_stream_encoder.sv - streaming SECDED encoder with injection and 2-entry FIFO
module hamming_stream_encoder
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      in_data,
    input  logic [15:0]      in_inj_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_code,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    code_t            mem_q [2];
    code_t            mem_d [2];
    logic [CNT_W-1:0] count_q, count_d;

    code_t enc_code;
    logic  push, pop;

    hamming_enc_core u_enc_core (
        .data (in_data),
        .code (enc_code)
    );

    // Handshake flags decode straight from the occupancy register.
    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign out_code  = mem_q[rd_ptr_q];
    assign out_count = count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc_code ^ in_inj_mask;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            count_d  = count_q + 1'b1;
        end
    end

    always_comb begin
        occ_d = occ_q;
        unique case (occ_q)
            OCC_EMPTY: if (push) occ_d = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_d = OCC_FULL;
                else if (pop && !push) occ_d = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_d = OCC_ONE;
            default:   occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= OCC_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            count_q  <= '0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// tb/tb_hamming_stream_encoder.sv - randomized self-checking bench for hamming_stream_encoder
module tb_hamming_stream_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [10:0] in_data;
    logic [15:0] in_inj_mask;
    logic        out_ready;
    logic        in_ready, in_ready4;
    logic        out_valid, out_valid4;
    logic [15:0] out_code, out_code4;
    logic [15:0] out_count;
    logic [3:0]  out_count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hamming_stream_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inj_mask(in_inj_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_code(out_code), .out_count(out_count)
    );

    hamming_stream_encoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_inj_mask(in_inj_mask), .out_valid(out_valid4),
        .out_ready(out_ready), .out_code(out_code4), .out_count(out_count4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Positions that are not powers of two carry data, in ascending order;
    // parity bit p covers every position whose index has bit p set.
    function automatic logic [15:0] model_encode(input logic [10:0] d);
        logic [16:0] pos;
        int          j;
        logic        b;
        pos = '0;
        j   = 0;
        for (int k = 1; k <= 15; k++)
            if ((k & (k - 1)) != 0) begin
                pos[k] = d[j];
                j++;
            end
        for (int p = 1; p <= 8; p = p * 2) begin
            b = 1'b0;
            for (int k = 1; k <= 15; k++)
                if ((k & p) != 0 && k != p) b = b ^ pos[k];
            pos[p] = b;
        end
        pos[16] = ^pos[15:1];
        return pos[16:1];
    endfunction

    task automatic model_decode(input logic [15:0] c, output logic err, output logic unc,
                                output logic [10:0] d);
        logic [16:0] pos;
        int          syn;
        logic        overall;
        int          j;
        pos     = {c, 1'b0};
        syn     = 0;
        for (int k = 1; k <= 15; k++)
            if (pos[k]) syn = syn ^ k;
        overall = ^c;
        err     = (syn != 0) || overall;
        unc     = (syn != 0) && !overall;
        if (overall && syn != 0) pos[syn] = ~pos[syn];
        j = 0;
        d = '0;
        for (int k = 1; k <= 15; k++)
            if ((k & (k - 1)) != 0) begin
                d[j] = pos[k];
                j++;
            end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [15:0] sb[$];
    int          exp_cnt;
    int          pushed;
    int          cycles;
    logic        e_err, e_unc;
    logic [10:0] e_data;
    logic        push_m, pop_m;
    logic [15:0] nxt;

    initial begin
        in_valid    = 1'b0;
        in_data     = '0;
        in_inj_mask = '0;
        out_ready   = 1'b0;
        rst_n       = 1'b0;
        #3;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_code", out_code, 0);
        check_eq("rst_out_count", out_count, 0);
        do_reset();

        // Known codewords back to back.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 11'h000;
        tick();
        check_eq("kc0_valid", out_valid, 1);
        check_eq("kc0_code", out_code, 16'h0000);
        in_data = 11'h001;
        tick();
        check_eq("kc1_code", out_code, 16'h8007);
        in_data = 11'h7FF;
        tick();
        check_eq("kc2_code", out_code, 16'hFFFF);
        check_eq("kc2_model", model_encode(11'h7FF), 16'hFFFF);
        in_valid = 1'b0;
        tick();
        check_eq("kc_drained", out_valid, 0);
        check_eq("kc_count", out_count, 3);

        // Backpressure.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h001;
        tick();
        check_eq("bp_ready1", in_ready, 1);
        in_data = 11'h7FF;
        tick();
        check_eq("bp_ready_low", in_ready, 0);
        check_eq("bp_head", out_code, 16'h8007);
        in_data = 11'h123;
        tick();
        tick();
        check_eq("bp_held_ready", in_ready, 0);
        check_eq("bp_stable", out_code, 16'h8007);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_eq("bp_second", out_code, 16'hFFFF);
        check_eq("bp_ready_rise", in_ready, 1);
        check_eq("bp_valid", out_valid, 1);
        tick();
        check_eq("bp_empty", out_valid, 0);
        check_eq("bp_count", out_count, 5);

        // Error injection seen through a reference decoder.
        in_valid    = 1'b1;
        in_data     = 11'h001;
        in_inj_mask = 16'h0010;
        tick();
        check_eq("inj1_code", out_code, 16'h8017);
        model_decode(out_code, e_err, e_unc, e_data);
        check_eq("inj1_err", e_err, 1);
        check_eq("inj1_unc", e_unc, 0);
        check_eq("inj1_data", e_data, 11'h001);
        in_inj_mask = 16'h0003;
        tick();
        check_eq("inj2_code", out_code, 16'h8004);
        model_decode(out_code, e_err, e_unc, e_data);
        check_eq("inj2_unc", e_unc, 1);
        in_valid    = 1'b0;
        in_inj_mask = '0;
        tick();

        // Reset in the middle of a full FIFO, no clock edge needed.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 11'h2A5;
        tick();
        tick();
        in_valid = 1'b0;
        check_eq("mr_full", in_ready, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", out_valid, 0);
        check_eq("mr_ready", in_ready, 1);
        check_eq("mr_count", out_count, 0);
        check_eq("mr_code", out_code, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("mr_no_ghost", out_valid, 0);
        check_eq("mr_count2", out_count, 0);

        // Random traffic against a scoreboard.
        exp_cnt = 0;
        pushed  = 0;
        cycles  = 0;
        while (pushed < 120 && cycles < 3000) begin
            check_eq("rnd_valid", out_valid, sb.size() != 0);
            check_eq("rnd_ready", in_ready, sb.size() != 2);
            check_eq("rnd_count", out_count, exp_cnt[15:0]);
            check_eq("rnd_count4", out_count4, exp_cnt[3:0]);
            if (sb.size() != 0) check_eq("rnd_code", out_code, sb[0]);
            in_valid    = ($urandom_range(3) != 0);
            out_ready   = ($urandom_range(3) != 0);
            in_data     = 11'($urandom);
            in_inj_mask = ($urandom_range(7) == 0) ? 16'($urandom) : 16'h0000;
            push_m      = in_valid && (sb.size() != 2);
            pop_m       = out_ready && (sb.size() != 0);
            nxt         = model_encode(in_data) ^ in_inj_mask;
            tick();
            if (pop_m) begin
                void'(sb.pop_front());
                exp_cnt++;
            end
            if (push_m) begin
                sb.push_back(nxt);
                pushed++;
            end
            cycles++;
        end
        check_eq("rnd_budget", cycles < 3000, 1);

        // Sustained throughput: one word per cycle with out_ready high.
        out_ready   = 1'b1;
        in_inj_mask = '0;
        for (int i = 0; i < 30; i++) begin
            if (sb.size() != 0) check_eq("thr_code", out_code, sb[0]);
            check_eq("thr_ready", in_ready, sb.size() != 2);
            in_valid = 1'b1;
            in_data  = 11'($urandom);
            push_m   = (sb.size() != 2);
            pop_m    = (sb.size() != 0);
            nxt      = model_encode(in_data);
            tick();
            if (pop_m) begin
                void'(sb.pop_front());
                exp_cnt++;
            end
            if (push_m) sb.push_back(nxt);
        end
        in_valid = 1'b0;
        while (sb.size() != 0) begin
            check_eq("thr_tail", out_code, sb[0]);
            void'(sb.pop_front());
            exp_cnt++;
            tick();
        end
        check_eq("thr_count", out_count, exp_cnt[15:0]);
        check_eq("thr_empty", out_valid, 0);

        // Counter wrap on the 4-bit instance.
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 11'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check_eq("wrap_count4", out_count4, 4'd1);
        check_eq("wrap_count16", out_count, 16'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
